conv_seq_ctrl: RTL and testbench
================================

# conv_seq_ctrl

Sequencer for the convolution accelerator. It sits between the APB register block, which supplies command, input_len_ex, output_len_ex, width_ex and reads back the done flags, and the feature/bias/weight read engines and the conv core. It turns one software command into an ordered series of start pulses and done waits. In AUTO mode it runs a full layer: feature load, then bias load, then weight load plus conv for every output channel.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65535: watchdog limit per wait state. Used only when CONV_SEQ_TIMEOUT_EN is defined.

Ports:
- PCLK  in  1  clock.
- PRESETB  in  1  reset, asynchronous, active-low.
- command  in  3  command register value. 0 = NOP, 1 = FEAT, 2 = BIAS, 3 = WGT, 4 = CONV, 5 = AUTO, 6 = reserved (illegal), 7 = ABORT.
- input_len_ex, output_len_ex, width_ex  in  9 each  layer geometry.
- feature_read_done, bias_read_done, weight_read_done, conv_done  in  1 each  engine done indications, level or pulse.
- feature_start, bias_start, weight_start, conv_start  out  1 each  one-cycle start pulses.
- cur_in_len, cur_out_len, cur_width  out  9 each  geometry latched at command accept.
- oc_idx  out  9  current output-channel index.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- seq_done  out  1  sticky completion flag.
- seq_err  out  1  sticky error flag.
- seq_state  out  4  state encoding, for APB readback.

## Operation
- Command accept:
  - cmd_q holds the registered previous value of command.
  - A command is accepted when command != cmd_q and command != 0.
  - Software writes 0 between commands. Rewriting the same nonzero value is ignored.
- On accept:
  - Latch cur_* from the inputs.
  - Clear seq_done and seq_err.
  - oc_idx <= 0.
- Commands are ignored while busy, except ABORT.
- ABORT from any state: next state IDLE, all start pulses suppressed, seq_done = 0, seq_err = 1.
- Illegal command (6) from IDLE: go to ERR.
- Zero-length check on accept:
  - FEAT/CONV/AUTO need input_len_ex != 0 and width_ex != 0.
  - AUTO/WGT/BIAS need output_len_ex != 0.
  - If a check fails, go to ERR and issue no start.
- States: IDLE, FEAT, BIAS, WGT, CONV, NEXT, DONE, ERR.
  - Each of FEAT, BIAS, WGT and CONV pulses its start for exactly one cycle on entry. It then waits for a rising edge of its done (done & ~done_q).
  - Single commands 1–4: IDLE -> X -> DONE.
  - AUTO: IDLE -> FEAT -> BIAS -> WGT -> CONV -> NEXT.
  - NEXT: if oc_idx == cur_out_len-1, go to DONE. Otherwise oc_idx++ and go to WGT.
  - DONE: seq_done = 1, then IDLE. ERR: seq_err = 1, then IDLE. Flags hold until the next accept.
- Done edges arriving in a state that does not wait on them are ignored.
- A done already high at entry does not count. A fresh rising edge is required.
- Reset values of all outputs: 0. State resets to IDLE.

## Timing
- Command visible in cycle T: accept at the T posedge. The first start pulse is high during T+1 (registered outputs).
- Done rising edge in cycle D: the next start pulse is high in D+1. DONE occupies D+1 and seq_done is high from D+2.
- NEXT costs 1 cycle.
- AUTO overhead with O output channels, excluding engine time: 4 + 3·O cycles.
- ABORT coinciding with a done edge: ABORT wins.
- Reset mid-operation: immediate return to IDLE with all outputs 0. In-flight engine state is not tracked.
- oc_idx wraps never. The maximum is 510, with cur_out_len ≤ 511.

## Configuration
- CONV_SEQ_TIMEOUT_EN defined:
  - A wait counter clears on entry to each wait state.
  - If it reaches TIMEOUT_CYCLES without a done edge, go to ERR and set seq_err.
  - seq_state reads 4'hF for one cycle in that case.
- Undefined: no counter, and the block waits indefinitely.

## Structure
- Package conv_seq_pkg holds:
  - the state enum and its 4-bit encodings;
  - the command code constants (CMD_NOP … CMD_ABORT);
  - the 9-bit length width constant.
- Sub-module conv_seq_wdog is the timeout counter. It has inputs clear and run, and output expire. It is instantiated only under CONV_SEQ_TIMEOUT_EN.

## Test plan
- AUTO with in=8, out=3, width=4, each done pulsed 5 cycles after its start:
  - start order is feature, bias, then (weight, conv) ×3;
  - oc_idx steps 0 -> 1 -> 2;
  - seq_done rises after the 3rd conv_done, and busy falls.
- Single CONV, then rewrite CONV without writing 0: only one conv_start. Write 0, then 4: a second conv_start.
- AUTO with output_len_ex = 0: no start pulses, seq_err = 1 within 2 cycles, seq_done = 0.
- ABORT during WGT, with weight_read_done asserted in the same cycle: IDLE next cycle, no conv_start, seq_err = 1.
- Change input_len_ex mid-AUTO: cur_in_len keeps the value latched at accept.
- With CONV_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 16, FEAT with feature_read_done held low: ERR after 16 cycles, seq_err = 1. Assert PRESETB low mid-wait: all outputs 0.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg
// Shared definitions for the convolution sequencer: geometry width, command
// codes and the sequencer state encoding reported on seq_state.
// Optional feature macro: CONV_SEQ_TIMEOUT_EN (watchdog per wait state).
package conv_seq_pkg;

  localparam int unsigned LEN_W = 9;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_FEAT  = 3'd1;
  localparam logic [2:0] CMD_BIAS  = 3'd2;
  localparam logic [2:0] CMD_WGT   = 3'd3;
  localparam logic [2:0] CMD_CONV  = 3'd4;
  localparam logic [2:0] CMD_AUTO  = 3'd5;
  localparam logic [2:0] CMD_RSVD  = 3'd6;
  localparam logic [2:0] CMD_ABORT = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE = 4'h0,
    ST_FEAT = 4'h1,
    ST_BIAS = 4'h2,
    ST_WGT  = 4'h3,
    ST_CONV = 4'h4,
    ST_NEXT = 4'h5,
    ST_DONE = 4'h6,
    ST_ERR  = 4'h7
  } seq_state_e;

  // Readback code shown for one cycle when a wait state times out.
  localparam logic [3:0] SEQ_STATE_TMO = 4'hF;

  // States that sit waiting for an engine done edge.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_FEAT) || (s == ST_BIAS) || (s == ST_WGT) || (s == ST_CONV);
  endfunction

endpackage

// File: rtl/conv_seq_wdog.sv
// conv_seq_wdog
// Wait-state watchdog for conv_seq_ctrl. Counts cycles while run is high and
// raises expire on the TIMEOUT_CYCLES-th consecutive waiting cycle.
// Only instantiated when CONV_SEQ_TIMEOUT_EN is defined.
// Ports:
//   PCLK, PRESETB  clock, asynchronous active-low reset
//   clear          restart the count (state entry)
//   run            currently in a wait state
//   expire         limit reached while running
module conv_seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic PCLK,
  input  logic PRESETB,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run && !expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Count value k is seen in the k-th cycle after entry, so the match on
  // TIMEOUT_CYCLES-1 fires in the TIMEOUT_CYCLES-th waiting cycle.
  assign expire = run && (r_cnt == LAST);

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl
// Convolution accelerator sequencer. Converts a software command into a chain
// of one-cycle engine start pulses and done-edge waits; AUTO runs a full layer
// (feature, bias, then weight+conv per output channel).
// Optional feature macro: CONV_SEQ_TIMEOUT_EN adds a per-wait-state watchdog.
// Ports:
//   PCLK, PRESETB                         clock, asynchronous active-low reset
//   command[2:0]                          command register (edge-accepted)
//   input_len_ex/output_len_ex/width_ex   layer geometry
//   *_read_done, conv_done                engine done (level or pulse)
//   *_start, conv_start                   one-cycle start pulses
//   cur_in_len/cur_out_len/cur_width      geometry latched on accept
//   oc_idx                                current output channel
//   busy, seq_done, seq_err, seq_state    status for APB readback
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             PCLK,
  input  logic             PRESETB,
  input  logic [2:0]       command,
  input  logic [LEN_W-1:0] input_len_ex,
  input  logic [LEN_W-1:0] output_len_ex,
  input  logic [LEN_W-1:0] width_ex,
  input  logic             feature_read_done,
  input  logic             bias_read_done,
  input  logic             weight_read_done,
  input  logic             conv_done,
  output logic             feature_start,
  output logic             bias_start,
  output logic             weight_start,
  output logic             conv_start,
  output logic [LEN_W-1:0] cur_in_len,
  output logic [LEN_W-1:0] cur_out_len,
  output logic [LEN_W-1:0] cur_width,
  output logic [LEN_W-1:0] oc_idx,
  output logic             busy,
  output logic             seq_done,
  output logic             seq_err,
  output logic [3:0]       seq_state
);

  seq_state_e       r_state, w_nxt;
  logic [2:0]       r_cmd_q;
  logic [3:0]       r_done_q;
  logic [3:0]       w_done, w_edge, w_start;
  logic             r_auto, w_auto_nxt;
  logic             w_accept, w_abort;
  logic             w_latch, w_clr_flags, w_set_done, w_set_err, w_oc_inc;
  logic             w_in_ok, w_out_ok;
  logic [LEN_W-1:0] w_last_oc;

  // Engine order in the done/start vectors: {conv, weight, bias, feature}.
  assign w_done    = {conv_done, weight_read_done, bias_read_done, feature_read_done};
  assign w_edge    = w_done & ~r_done_q;
  assign w_accept  = (command != r_cmd_q) && (command != CMD_NOP);
  assign w_abort   = w_accept && (command == CMD_ABORT);
  assign w_in_ok   = (input_len_ex != '0) && (width_ex != '0);
  assign w_out_ok  = (output_len_ex != '0);
  assign w_last_oc = cur_out_len - LEN_W'(1);

`ifdef CONV_SEQ_TIMEOUT_EN
  logic w_expire, w_tmo, r_tmo;
`endif

  always_comb begin
    w_nxt       = r_state;
    w_auto_nxt  = r_auto;
    w_latch     = 1'b0;
    w_clr_flags = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    w_oc_inc    = 1'b0;
    if (w_abort) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          w_nxt      = ST_IDLE;
          w_set_done = (r_state == ST_DONE);
          w_set_err  = (r_state == ST_ERR);
          if (w_accept) begin
            w_latch     = 1'b1;
            w_clr_flags = 1'b1;
            w_auto_nxt  = (command == CMD_AUTO);
            case (command)
              CMD_FEAT: w_nxt = w_in_ok ? ST_FEAT : ST_ERR;
              CMD_BIAS: w_nxt = w_out_ok ? ST_BIAS : ST_ERR;
              CMD_WGT:  w_nxt = w_out_ok ? ST_WGT : ST_ERR;
              CMD_CONV: w_nxt = w_in_ok ? ST_CONV : ST_ERR;
              CMD_AUTO: w_nxt = (w_in_ok && w_out_ok) ? ST_FEAT : ST_ERR;
              default:  w_nxt = ST_ERR;
            endcase
          end
        end
        ST_FEAT: if (w_edge[0]) w_nxt = r_auto ? ST_BIAS : ST_DONE;
        ST_BIAS: if (w_edge[1]) w_nxt = r_auto ? ST_WGT : ST_DONE;
        ST_WGT:  if (w_edge[2]) w_nxt = r_auto ? ST_CONV : ST_DONE;
        ST_CONV: if (w_edge[3]) w_nxt = r_auto ? ST_NEXT : ST_DONE;
        ST_NEXT: begin
          if (oc_idx == w_last_oc) begin
            w_nxt = ST_DONE;
          end else begin
            w_oc_inc = 1'b1;
            w_nxt    = ST_WGT;
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
`ifdef CONV_SEQ_TIMEOUT_EN
    // A done edge in the expiring cycle still wins over the timeout.
    w_tmo = !w_abort && is_wait_state(r_state) && (w_nxt == r_state) && w_expire;
    if (w_tmo) w_nxt = ST_ERR;
`endif
    // Starts fire only on entry; wait states are never re-entered from themselves.
    w_start[0] = (w_nxt == ST_FEAT) && (r_state != ST_FEAT);
    w_start[1] = (w_nxt == ST_BIAS) && (r_state != ST_BIAS);
    w_start[2] = (w_nxt == ST_WGT)  && (r_state != ST_WGT);
    w_start[3] = (w_nxt == ST_CONV) && (r_state != ST_CONV);
  end

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      r_state       <= ST_IDLE;
      r_cmd_q       <= '0;
      r_done_q      <= '0;
      r_auto        <= 1'b0;
      feature_start <= 1'b0;
      bias_start    <= 1'b0;
      weight_start  <= 1'b0;
      conv_start    <= 1'b0;
      cur_in_len    <= '0;
      cur_out_len   <= '0;
      cur_width     <= '0;
      oc_idx        <= '0;
      seq_done      <= 1'b0;
      seq_err       <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cmd_q  <= command;
      r_done_q <= w_done;
      r_auto   <= w_auto_nxt;
      {conv_start, weight_start, bias_start, feature_start} <= w_start;
      if (w_latch) begin
        cur_in_len  <= input_len_ex;
        cur_out_len <= output_len_ex;
        cur_width   <= width_ex;
        oc_idx      <= '0;
      end else if (w_oc_inc) begin
        oc_idx <= oc_idx + LEN_W'(1);
      end
      if (w_abort) begin
        seq_done <= 1'b0;
        seq_err  <= 1'b1;
      end else if (w_clr_flags) begin
        seq_done <= 1'b0;
        seq_err  <= 1'b0;
      end else begin
        if (w_set_done) seq_done <= 1'b1;
        if (w_set_err)  seq_err  <= 1'b1;
      end
    end
  end

  assign busy = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);

`ifdef CONV_SEQ_TIMEOUT_EN
  conv_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .PCLK   (PCLK),
    .PRESETB(PRESETB),
    .clear  (w_nxt != r_state),
    .run    (is_wait_state(r_state)),
    .expire (w_expire)
  );

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) r_tmo <= 1'b0;
    else          r_tmo <= w_tmo;
  end

  assign seq_state = r_tmo ? SEQ_STATE_TMO : 4'(r_state);
`else
  assign seq_state = 4'(r_state);
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESETB = 1'b0;
  logic [2:0] command = '0;
  logic [8:0] input_len_ex = '0, output_len_ex = '0, width_ex = '0;
  logic       feature_read_done = 1'b0, bias_read_done = 1'b0;
  logic       weight_read_done = 1'b0, conv_done = 1'b0;
  logic       feature_start, bias_start, weight_start, conv_start;
  logic [8:0] cur_in_len, cur_out_len, cur_width, oc_idx;
  logic       busy, seq_done, seq_err;
  logic [3:0] seq_state;

  conv_seq_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETB(PRESETB), .command(command),
    .input_len_ex(input_len_ex), .output_len_ex(output_len_ex), .width_ex(width_ex),
    .feature_read_done(feature_read_done), .bias_read_done(bias_read_done),
    .weight_read_done(weight_read_done), .conv_done(conv_done),
    .feature_start(feature_start), .bias_start(bias_start),
    .weight_start(weight_start), .conv_start(conv_start),
    .cur_in_len(cur_in_len), .cur_out_len(cur_out_len), .cur_width(cur_width),
    .oc_idx(oc_idx), .busy(busy), .seq_done(seq_done), .seq_err(seq_err),
    .seq_state(seq_state)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observation log: one entry per start pulse cycle.
  int ev_kind[$], ev_cyc[$], ev_oc[$], ev_done[$];
  int pend[4], cd[4];
  logic [3:0] lvl;
  bit level_mode, scramble;
  int lat_lo, lat_hi;
  int t_cmd, rise_done, rise_err, fall_busy, rise_tmo;
  int abort_k, abort_at, wcount;

  task automatic clear_log();
    ev_kind.delete(); ev_cyc.delete(); ev_oc.delete(); ev_done.delete();
    for (int e = 0; e < 4; e++) begin pend[e] = -1; cd[e] = 0; end
    lvl = '0; rise_done = -1; rise_err = -1; fall_busy = -1; rise_tmo = -1;
    abort_at = -1; abort_k = 0; wcount = 0; scramble = 0; level_mode = 0;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [8:0] il, ol, wd);
    @(negedge PCLK);
    command = '0;
    {conv_done, weight_read_done, bias_read_done, feature_read_done} = '0;
    @(negedge PCLK);
    command = c; input_len_ex = il; output_len_ex = ol; width_ex = wd;
    t_cmd = cyc;
  endtask

  // Engine responder + monitor; stops tail cycles after seq_done/seq_err rises.
  task automatic run(input int max_cyc, input int tail);
    logic [3:0] dn, st;
    int left;
    left = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge PCLK);
      dn = level_mode ? lvl : 4'b0000;
      for (int e = 0; e < 4; e++) begin
        if (cd[e] > 0) begin
          cd[e]--;
          if (cd[e] == 0) begin
            dn[e] = 1'b1;
            if (pend[e] >= 0) ev_done[pend[e]] = cyc;
            pend[e] = -1;
          end
        end
      end
      st = {conv_start, weight_start, bias_start, feature_start};
      for (int e = 0; e < 4; e++) begin
        if (st[e]) begin
          ev_kind.push_back(e); ev_cyc.push_back(cyc);
          ev_oc.push_back(int'(oc_idx)); ev_done.push_back(-1);
          if (lat_hi > 0) begin
            cd[e] = $urandom_range(lat_hi, lat_lo);
            pend[e] = ev_kind.size() - 1;
            dn[e] = 1'b0;
          end
          if (e == 2) begin
            wcount++;
            if (wcount == abort_k) abort_at = cyc + 2;
          end
        end
      end
      if (seq_done && rise_done < 0) rise_done = cyc;
      if (seq_err && rise_err < 0) rise_err = cyc;
      if (seq_state == 4'hF && rise_tmo < 0) rise_tmo = cyc;
      if (!busy && cyc > t_cmd && fall_busy < 0) fall_busy = cyc;
      if (abort_at >= 0 && cyc == abort_at) begin
        command = 3'd7;
        dn[2] = 1'b1;
      end
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        checks++;
        if ({busy, seq_state, seq_err, seq_done, st} !== {1'b0, 4'h0, 1'b1, 1'b0, 4'b0000}) begin
          errors++;
          $display("FAIL abort_next_cycle: busy/state/err/done/starts got %b %h %b %b %b required 0 0 1 0 0000",
                   busy, seq_state, seq_err, seq_done, st);
        end
      end
      {conv_done, weight_read_done, bias_read_done, feature_read_done} = dn;
      lvl = level_mode ? dn : 4'b0000;
      if (scramble) begin
        input_len_ex = 9'($urandom); output_len_ex = 9'($urandom); width_ex = 9'($urandom);
      end
      if (left < 0 && (rise_done >= 0 || rise_err >= 0)) left = tail;
      if (left == 0) break;
      if (left > 0) left--;
    end
  endtask

  // Reference: expected order from the command, start times from the done
  // cycles observed, plus the overall AUTO overhead formula.
  task automatic check_seq(input logic [2:0] c, input int il, ol, wd, input string tag);
    int exp_k[$];
    int n, exp_t, exp_oc, sum_l, last, au;
    au = (c == 3'd5) ? 1 : 0;
    if (au == 1) begin
      exp_k.push_back(0); exp_k.push_back(1);
      for (int j = 0; j < ol; j++) begin exp_k.push_back(2); exp_k.push_back(3); end
    end else begin
      exp_k.push_back(int'(c) - 1);
    end
    checks++;
    if (ev_kind.size() != exp_k.size()) begin
      errors++;
      $display("FAIL %s start_count: got %0d required %0d", tag, ev_kind.size(), exp_k.size());
    end
    n = (ev_kind.size() < exp_k.size()) ? ev_kind.size() : exp_k.size();
    sum_l = 0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ev_kind[i] != exp_k[i]) begin
        errors++;
        $display("FAIL %s start_kind[%0d]: got %0d required %0d", tag, i, ev_kind[i], exp_k[i]);
      end
      exp_t = (i == 0) ? t_cmd + 1 : ev_done[i-1] + 1 + ((au == 1 && ev_kind[i-1] == 3) ? 1 : 0);
      checks++;
      if (ev_cyc[i] != exp_t) begin
        errors++;
        $display("FAIL %s start_cycle[%0d]: got %0d required %0d", tag, i, ev_cyc[i], exp_t);
      end
      exp_oc = (au == 1 && i >= 2) ? (i - 2) / 2 : 0;
      checks++;
      if (ev_oc[i] != exp_oc) begin
        errors++;
        $display("FAIL %s oc_idx[%0d]: got %0d required %0d", tag, i, ev_oc[i], exp_oc);
      end
      sum_l += ev_done[i] - ev_cyc[i];
    end
    last = (n > 0) ? ev_done[n-1] : -100;
    checks++;
    if (rise_done != last + 2 + au) begin
      errors++;
      $display("FAIL %s seq_done_rise: got %0d required %0d", tag, rise_done, last + 2 + au);
    end
    checks++;
    if (fall_busy != last + 1 + au) begin
      errors++;
      $display("FAIL %s busy_fall: got %0d required %0d", tag, fall_busy, last + 1 + au);
    end
    if (au == 1) begin
      checks++;
      if (rise_done - t_cmd - sum_l != 4 + 3 * ol) begin
        errors++;
        $display("FAIL %s auto_overhead: got %0d required %0d", tag, rise_done - t_cmd - sum_l, 4 + 3 * ol);
      end
    end
    checks++;
    if (rise_err != -1) begin
      errors++;
      $display("FAIL %s seq_err_unexpected: got cycle %0d required none", tag, rise_err);
    end
    checks++;
    if ({cur_in_len, cur_out_len, cur_width} !== {9'(il), 9'(ol), 9'(wd)}) begin
      errors++;
      $display("FAIL %s cur_geom: got %0d/%0d/%0d required %0d/%0d/%0d", tag,
               cur_in_len, cur_out_len, cur_width, il, ol, wd);
    end
    checks++;
    if ({seq_done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL %s final_done_busy: got %b required 10", tag, {seq_done, busy});
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({feature_start, bias_start, weight_start, conv_start, cur_in_len, cur_out_len,
         cur_width, oc_idx, busy, seq_done, seq_err, seq_state} !== 47'd0) begin
      errors++;
      $display("FAIL %s: outputs got %h required 0", tag,
               {feature_start, bias_start, weight_start, conv_start, cur_in_len, cur_out_len,
                cur_width, oc_idx, busy, seq_done, seq_err, seq_state});
    end
  endtask

  task automatic test_reset();
    PRESETB = 1'b0;
    repeat (3) @(negedge PCLK);
    check_all_zero("reset_held");
    PRESETB = 1'b1;
    repeat (2) @(negedge PCLK);
    check_all_zero("reset_released_idle");
  endtask

  task automatic test_auto_plan();
    clear_log();
    lat_lo = 5; lat_hi = 5; scramble = 1;
    send_cmd(3'd5, 9'd8, 9'd3, 9'd4);
    run(400, 3);
    check_seq(3'd5, 8, 3, 4, "auto_plan");
  endtask

  task automatic test_auto_random();
    int il, ol, wd;
    for (int it = 0; it < 4; it++) begin
      clear_log();
      il = $urandom_range(511, 1); ol = $urandom_range(4, 1); wd = $urandom_range(511, 1);
      lat_lo = 1; lat_hi = 6; scramble = 1; level_mode = $urandom_range(1, 0);
      send_cmd(3'd5, 9'(il), 9'(ol), 9'(wd));
      run(600, 3);
      check_seq(3'd5, il, ol, wd, "auto_random");
    end
  endtask

  task automatic test_single();
    int c, il, ol, wd;
    for (int it = 0; it < 8; it++) begin
      clear_log();
      c  = (it < 4) ? it + 1 : $urandom_range(4, 1);
      il = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(511, 1);
      ol = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(511, 1);
      wd = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(511, 1);
      if (c == 1 || c == 4) begin
        if (il == 0) il = 1;
        if (wd == 0) wd = 2;
      end else if (ol == 0) begin
        ol = 3;
      end
      lat_lo = 1; lat_hi = 6; level_mode = $urandom_range(1, 0);
      send_cmd(3'(c), 9'(il), 9'(ol), 9'(wd));
      run(100, 3);
      check_seq(3'(c), il, ol, wd, "single");
    end
  endtask

  task automatic test_rewrite();
    clear_log();
    lat_lo = 3; lat_hi = 3;
    send_cmd(3'd4, 9'd6, 9'd2, 9'd5);
    run(100, 3);
    check_seq(3'd4, 6, 2, 5, "rewrite_first");
    clear_log();
    lat_lo = 3; lat_hi = 3;
    command = 3'd4;
    run(20, 20);
    checks++;
    if (ev_kind.size() != 0) begin
      errors++;
      $display("FAIL rewrite_same_ignored: starts got %0d required 0", ev_kind.size());
    end
    clear_log();
    lat_lo = 3; lat_hi = 3;
    send_cmd(3'd4, 9'd7, 9'd1, 9'd9);
    run(100, 3);
    check_seq(3'd4, 7, 1, 9, "rewrite_after_zero");
  endtask

  task automatic test_zero_len();
    logic [35:0] tbl [8];
    logic [2:0] c;
    logic [8:0] il, ol, wd;
    tbl[0] = {3'd5, 9'd8, 9'd0, 9'd4, 6'd0};
    tbl[1] = {3'd1, 9'd0, 9'd3, 9'd4, 6'd0};
    tbl[2] = {3'd4, 9'd5, 9'd5, 9'd0, 6'd0};
    tbl[3] = {3'd2, 9'd5, 9'd0, 9'd5, 6'd0};
    tbl[4] = {3'd3, 9'd7, 9'd0, 9'd2, 6'd0};
    tbl[5] = {3'd5, 9'd0, 9'd3, 9'd3, 6'd0};
    tbl[6] = {3'd6, 9'd3, 9'd3, 9'd3, 6'd0};
    tbl[7] = {3'd5, 9'd4, 9'd2, 9'd0, 6'd0};
    for (int i = 0; i < 8; i++) begin
      clear_log();
      lat_lo = 2; lat_hi = 2;
      {c, il, ol, wd} = tbl[i][35:6];
      send_cmd(c, il, ol, wd);
      run(12, 3);
      checks++;
      if (ev_kind.size() != 0 || rise_done != -1) begin
        errors++;
        $display("FAIL zero_len[%0d] starts/done: got %0d/%0d required 0/-1", i, ev_kind.size(), rise_done);
      end
      checks++;
      if (rise_err < t_cmd + 1 || rise_err > t_cmd + 2) begin
        errors++;
        $display("FAIL zero_len[%0d] seq_err_rise: got %0d required %0d..%0d", i, rise_err, t_cmd + 1, t_cmd + 2);
      end
    end
  endtask

  task automatic test_abort();
    clear_log();
    lat_lo = 5; lat_hi = 5; abort_k = 2;
    send_cmd(3'd5, 9'd4, 9'd4, 9'd4);
    run(300, 6);
    checks++;
    if (ev_kind.size() != 5 || (ev_kind.size() == 5 && ev_kind[4] != 2)) begin
      errors++;
      $display("FAIL abort_starts: got count %0d required 5 ending in weight", ev_kind.size());
    end
    checks++;
    if (rise_err != abort_at + 1 || rise_done != -1) begin
      errors++;
      $display("FAIL abort_flags: err rise %0d done rise %0d required %0d and -1", rise_err, rise_done, abort_at + 1);
    end
  endtask

  task automatic test_stale_done();
    int d;
    clear_log();
    @(negedge PCLK);
    command = '0; bias_read_done = 1'b1;
    input_len_ex = 9'd3; output_len_ex = 9'd3; width_ex = 9'd3;
    @(negedge PCLK);
    command = 3'd2; t_cmd = cyc;
    lat_hi = 0; level_mode = 1; lvl = 4'b0010;
    run(10, 0);
    checks++;
    if (rise_done != -1 || busy !== 1'b1 || ev_kind.size() != 1) begin
      errors++;
      $display("FAIL stale_done_ignored: done rise %0d busy %b starts %0d required -1 1 1",
               rise_done, busy, ev_kind.size());
    end
    @(negedge PCLK);
    bias_read_done = 1'b0;
    @(negedge PCLK);
    bias_read_done = 1'b1; d = cyc;
    @(negedge PCLK);
    checks++;
    if ({busy, seq_done} !== 2'b00) begin
      errors++;
      $display("FAIL stale_fresh_edge_done_state: busy/done got %b required 00 at %0d", {busy, seq_done}, d + 1);
    end
    @(negedge PCLK);
    checks++;
    if (seq_done !== 1'b1) begin
      errors++;
      $display("FAIL stale_fresh_edge_seq_done: got %b required 1", seq_done);
    end
    bias_read_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_log();
    lat_hi = 0;
    send_cmd(3'd1, 9'd5, 9'd5, 9'd5);
    run(6, 0);
    #2 PRESETB = 1'b0;
    #1 check_all_zero("reset_mid_async");
    command = '0;
    @(negedge PCLK);
    PRESETB = 1'b1;
    @(negedge PCLK);
    check_all_zero("reset_mid_after_release");
  endtask

`ifdef CONV_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    clear_log();
    lat_hi = 0;
    send_cmd(3'd1, 9'd5, 9'd5, 9'd5);
    run(40, 2);
    checks++;
    if (rise_tmo != t_cmd + 17) begin
      errors++;
      $display("FAIL timeout_state_f: got cycle %0d required %0d", rise_tmo, t_cmd + 17);
    end
    checks++;
    if (rise_err != t_cmd + 18 || ev_kind.size() != 1) begin
      errors++;
      $display("FAIL timeout_seq_err: got cycle %0d starts %0d required %0d and 1", rise_err, ev_kind.size(), t_cmd + 18);
    end
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL global_time_limit: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    clear_log();
    lat_lo = 1; lat_hi = 1;
    test_reset();
    test_auto_plan();
    test_auto_random();
    test_single();
    test_rewrite();
    test_zero_len();
    test_abort();
    test_stale_done();
`ifdef CONV_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
